// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_elastic
//  Description : Elastic pipeline register for any inter-stage boundary.
//                The payload is split into a control field, forced to zero
//                whenever no valid payload is presented, and a data field
//                that simply holds when the stage empties or is flushed.
//                A 2-entry skid buffer (main + skid) decouples in_ready from
//                out_ready so there is no combinational ready path through
//                the stage.
//                Optional feature macro: PIPE_STAT_EN
//                  defined   -> saturating stall/bubble counters
//                  undefined -> stall_cnt / bubble_cnt tied to zero
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 160,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // ------------------------------------------------------------------------
    // State encoding: bit 0 is the main-entry valid bit, bit 1 is the
    // skid-entry valid bit. The combination skid-only (2'b10) is unreachable.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CTRL_W-1:0]  r_m_ctrl;
    logic [DATA_W-1:0]  r_m_data;
    logic [CTRL_W-1:0]  r_s_ctrl;
    logic [DATA_W-1:0]  r_s_data;
    logic [1:0]         r_occupancy;

    logic               w_m_valid;
    logic               w_s_valid;
    logic               w_accept;
    logic               w_pop;

    // Register-load controls produced by the next-state logic
    logic               w_load_main_in;
    logic               w_load_main_skid;
    logic               w_load_skid_in;
    logic               w_clr_main_ctrl;
    logic               w_clr_skid_ctrl;
    logic [1:0]         w_occupancy_nxt;

    assign w_m_valid = r_state[0];
    assign w_s_valid = r_state[1];

    // Ready is a pure function of the registered skid valid bit, so upstream
    // never sees a combinational dependency on out_ready or flush.
    assign in_ready  = ~w_s_valid;
    assign out_valid = w_m_valid;
    assign out_ctrl  = r_m_ctrl;
    assign out_data  = r_m_data;
    assign occupancy = r_occupancy;

    assign w_accept  = in_valid & in_ready;
    assign w_pop     = w_m_valid & out_ready;

    // Next-state and register-load decode; flush overrides every handshake.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        w_clr_main_ctrl  = 1'b0;
        w_clr_skid_ctrl  = 1'b0;

        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    // Full throughput: the popped main entry is replaced.
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    // Downstream stalled: park the new payload in the skid.
                    w_load_skid_in = 1'b1;
                    w_state_nxt    = ST_FULL;
                end else if (w_pop) begin
                    // Going empty: zero ctrl so the bubble reads as a NOP.
                    w_clr_main_ctrl = 1'b1;
                    w_state_nxt     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can occur.
                if (w_pop) begin
                    w_load_main_skid = 1'b1;
                    w_clr_skid_ctrl  = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase

        if (flush) begin
            // Discard both entries; data registers keep their value to avoid
            // needless toggling, only the control fields are cleared.
            w_state_nxt      = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid_in   = 1'b0;
            w_clr_main_ctrl  = 1'b1;
            w_clr_skid_ctrl  = 1'b1;
        end
    end

    // Occupancy is derived from the next state so it is itself a flop output.
    always_comb begin
        w_occupancy_nxt = c_OCC_EMPTY;
        case (w_state_nxt)
            ST_EMPTY: w_occupancy_nxt = c_OCC_EMPTY;
            ST_ONE:   w_occupancy_nxt = c_OCC_ONE;
            ST_FULL:  w_occupancy_nxt = c_OCC_FULL;
            default:  w_occupancy_nxt = c_OCC_EMPTY;
        endcase
    end

    // State and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_occupancy <= c_OCC_EMPTY;
        end else begin
            r_state     <= w_state_nxt;
            r_occupancy <= w_occupancy_nxt;
        end
    end

    // Main-entry control field: cleared on empty/flush, loaded from input or skid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_ctrl <= '0;
        end else if (w_clr_main_ctrl) begin
            r_m_ctrl <= '0;
        end else if (w_load_main_in) begin
            r_m_ctrl <= in_ctrl;
        end else if (w_load_main_skid) begin
            r_m_ctrl <= r_s_ctrl;
        end
    end

    // Main-entry data field: written only on a real transfer, otherwise held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_data <= '0;
        end else if (w_load_main_in) begin
            r_m_data <= in_data;
        end else if (w_load_main_skid) begin
            r_m_data <= r_s_data;
        end
    end

    // Skid-entry control field: cleared when drained or flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_ctrl <= '0;
        end else if (w_clr_skid_ctrl) begin
            r_s_ctrl <= '0;
        end else if (w_load_skid_in) begin
            r_s_ctrl <= in_ctrl;
        end
    end

    // Skid-entry data field: captured only when the stage goes FULL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_data <= '0;
        end else if (w_load_skid_in) begin
            r_s_data <= in_data;
        end
    end

`ifdef PIPE_STAT_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating stall counter; flush does not clear it, the flush cycle
    // itself is classified by the pre-flush out_valid/out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_m_valid && !out_ready && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    // Saturating bubble counter for every cycle without a valid output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if (!w_m_valid && (r_bubble_cnt != c_CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    // Statistics disabled: ports kept for interface stability.
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
`default_nettype wire
